// File: rtl/bp_pkg.sv
// Shared types and constants for the static branch predictor and its execute-stage resolver.
package bp_pkg;

  localparam int unsigned DataWidth = 32;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef struct packed {
    logic [DataWidth-1:0] pc;
    logic [DataWidth-1:0] pred_target;
    logic                 pred_taken;
  } bp_entry_t;

  typedef enum logic [0:0] {
    RUN,
    FLUSH
  } res_state_t;

endpackage

// File: rtl/branch_resolver_if.sv
// Fetch/execute-facing signal bundle of the branch resolver.
interface branch_resolver_if #(
  parameter int unsigned DATA_WIDTH = 32
);

  logic                  push_valid;
  logic [DATA_WIDTH-1:0] push_pc;
  logic                  push_pred_taken;
  logic [DATA_WIDTH-1:0] push_pred_target;
  logic                  push_ready;
  logic                  res_valid;
  logic                  res_taken;
  logic [DATA_WIDTH-1:0] res_target;
  logic                  flush;
  logic [DATA_WIDTH-1:0] redirect_pc;
  logic                  queue_empty;
  logic                  res_error;
  logic [31:0]           branch_count;
  logic [31:0]           mispredict_count;

  modport master (
    output push_valid, push_pc, push_pred_taken, push_pred_target,
    output res_valid, res_taken, res_target,
    input  push_ready, flush, redirect_pc, queue_empty, res_error,
    input  branch_count, mispredict_count
  );

  modport slave (
    input  push_valid, push_pc, push_pred_taken, push_pred_target,
    input  res_valid, res_taken, res_target,
    output push_ready, flush, redirect_pc, queue_empty, res_error,
    output branch_count, mispredict_count
  );

endinterface

// File: rtl/pred_fifo.sv
// In-order queue of outstanding predictions; clear wins over push and pop.
module pred_fifo
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  logic      pop,
  input  logic      clear,
  input  bp_entry_t wdata,
  output bp_entry_t rdata,
  output logic      full,
  output logic      empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Extra wrap bit distinguishes full from empty when the indices match.
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  bp_entry_t   mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push && !full) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop && !empty) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full && !clear) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

  always_comb begin
    rdata = mem_q[rd_ptr_q[AW-1:0]];
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  end

endmodule

// File: rtl/branch_resolver.sv
// Compares execute outcomes with recorded fetch predictions; flushes and redirects on mismatch.
module branch_resolver
  import bp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  branch_resolver_if.slave bus
);

  res_state_t            state_q, state_d;
  bp_entry_t             head, push_entry;
  logic                  fifo_full, fifo_empty;
  logic                  in_run, push_acc, res_fire, mispredict, mis_fire, empty_res;
  logic [DATA_WIDTH-1:0] redirect_q;
  logic [31:0]           branch_q, mispred_q;
  logic                  res_error_q;

  always_comb begin
    push_entry = '{pc: bus.push_pc, pred_target: bus.push_pred_target,
                   pred_taken: bus.push_pred_taken};
    in_run     = (state_q == RUN);
    push_acc   = bus.push_valid && !fifo_full && in_run;
    res_fire   = bus.res_valid && in_run && !fifo_empty;
    empty_res  = bus.res_valid && in_run && fifo_empty;
    mispredict = (head.pred_taken != bus.res_taken) ||
                 (bus.res_taken && (head.pred_target != bus.res_target));
    mis_fire   = res_fire && mispredict;
  end

  // A mispredict clears the queue, which also drops any same-cycle wrong-path push.
  pred_fifo #(
    .DEPTH (DEPTH)
  ) u_pred_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_acc),
    .pop   (res_fire),
    .clear (mis_fire),
    .wdata (push_entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (mis_fire) state_d = FLUSH;
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    bus.flush      = (state_q == FLUSH);
    bus.push_ready = !fifo_full && (state_q == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_q  <= '0;
      branch_q    <= '0;
      mispred_q   <= '0;
      res_error_q <= 1'b0;
    end else begin
      if (res_fire)  branch_q    <= branch_q + 32'd1;
      if (mis_fire)  mispred_q   <= mispred_q + 32'd1;
      if (empty_res) res_error_q <= 1'b1;
      if (mis_fire) begin
        redirect_q <= bus.res_taken ? bus.res_target : head.pc + DataWidth'(4);
      end
    end
  end

  always_comb begin
    bus.redirect_pc      = redirect_q;
    bus.queue_empty      = fifo_empty;
    bus.res_error        = res_error_q;
    bus.branch_count     = branch_q;
    bus.mispredict_count = mispred_q;
  end

endmodule

// File: tb/tb_branch_resolver.sv
// Directed and random checks of branch_resolver against a queue-based behavioural model.
module tb_branch_resolver;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  branch_resolver_if #(.DATA_WIDTH(DW)) bus ();

  branch_resolver #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] tgt;
  } ent_t;

  ent_t        mq[$];
  int unsigned m_bc, m_mc;
  logic        m_err, m_flush;
  logic [31:0] m_redir;
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_bc = 0; m_mc = 0; m_err = 1'b0; m_flush = 1'b0; m_redir = '0;
  endtask

  task automatic drive(input logic pv, input logic [31:0] ppc, input logic pt,
                       input logic [31:0] ptg, input logic rv, input logic rt,
                       input logic [31:0] rtg);
    bus.push_valid = pv; bus.push_pc = ppc; bus.push_pred_taken = pt;
    bus.push_pred_target = ptg; bus.res_valid = rv; bus.res_taken = rt; bus.res_target = rtg;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  // One clock: predict from the model, advance the DUT, compare every observable.
  task automatic cycle(input string tag);
    logic ready, mis, nf;
    ent_t h;
    ready = !m_flush && (mq.size() < DEPTH);
    mis = 1'b0; nf = 1'b0;
    chk({tag, "/push_ready"}, 32'(bus.push_ready), 32'(ready));
    if (!m_flush) begin
      if (bus.res_valid) begin
        if (mq.size() == 0) m_err = 1'b1;
        else begin
          h = mq.pop_front();
          m_bc++;
          mis = (h.taken != bus.res_taken) || (bus.res_taken && h.tgt != bus.res_target);
          if (mis) begin
            m_mc++;
            mq.delete();
            m_redir = bus.res_taken ? bus.res_target : h.pc + 32'd4;
            nf = 1'b1;
          end
        end
      end
      if (bus.push_valid && ready && !mis)
        mq.push_back('{pc: bus.push_pc, taken: bus.push_pred_taken, tgt: bus.push_pred_target});
    end
    m_flush = nf;
    @(posedge clk);
    #1;
    chk({tag, "/flush"}, 32'(bus.flush), 32'(m_flush));
    if (m_flush) chk({tag, "/redirect_pc"}, bus.redirect_pc, m_redir);
    chk({tag, "/queue_empty"}, 32'(bus.queue_empty), 32'(mq.size() == 0));
    chk({tag, "/branch_count"}, bus.branch_count, m_bc);
    chk({tag, "/mispredict_count"}, bus.mispredict_count, m_mc);
    chk({tag, "/res_error"}, 32'(bus.res_error), 32'(m_err));
  endtask

  initial begin
    logic        pv, pt, rv, rt;
    logic [31:0] ppc, ptg, rtg;
    rst_n = 1'b0;
    idle();
    model_reset();
    #12;
    chk("reset/flush", 32'(bus.flush), 32'd0);
    chk("reset/redirect_pc", bus.redirect_pc, 32'd0);
    chk("reset/res_error", 32'(bus.res_error), 32'd0);
    chk("reset/branch_count", bus.branch_count, 32'd0);
    chk("reset/mispredict_count", bus.mispredict_count, 32'd0);
    chk("reset/queue_empty", 32'(bus.queue_empty), 32'd1);
    chk("reset/push_ready", 32'(bus.push_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Correct taken prediction.
    drive(1'b1, 32'h100, 1'b1, 32'h0F0, 1'b0, 1'b0, '0);  cycle("t1_push");
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 32'h0F0);        cycle("t1_res");
    chk("t1/branch_count", bus.branch_count, 32'd1);
    chk("t1/mispredict_count", bus.mispredict_count, 32'd0);

    // Predicted not-taken, actually taken.
    drive(1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 1'b0, '0);    cycle("t2_push");
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 32'h180);        cycle("t2_res");
    chk("t2/flush", 32'(bus.flush), 32'd1);
    chk("t2/redirect_pc", bus.redirect_pc, 32'h180);
    idle();                                                 cycle("t2_after");
    chk("t2/flush_low", 32'(bus.flush), 32'd0);

    // Predicted taken, actually not-taken, with younger entries and a same-cycle push.
    drive(1'b1, 32'h300, 1'b1, 32'h280, 1'b0, 1'b0, '0);  cycle("t3_push0");
    drive(1'b1, 32'h310, 1'b0, 32'h0, 1'b0, 1'b0, '0);    cycle("t3_push1");
    drive(1'b1, 32'h320, 1'b1, 32'h500, 1'b0, 1'b0, '0);  cycle("t3_push2");
    drive(1'b1, 32'h400, 1'b0, 32'h0, 1'b1, 1'b0, '0);    cycle("t3_res");
    chk("t3/redirect_pc", bus.redirect_pc, 32'h304);
    chk("t3/queue_empty", 32'(bus.queue_empty), 32'd1);
    chk("t3/push_ready_in_flush", 32'(bus.push_ready), 32'd0);
    drive(1'b1, 32'h410, 1'b0, 32'h0, 1'b1, 1'b1, 32'h999); cycle("t3_in_flush");
    drive(1'b1, 32'h500, 1'b0, 32'h0, 1'b0, 1'b0, '0);    cycle("t3_push_new");
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, '0);             cycle("t3_res_new");

    // Fill, overflow, refused push at full, occupancy-holding push+pop, ordered drain.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h600 + 32'(i) * 32'h10, 1'b1, 32'h640 + 32'(i) * 32'h10, 1'b0, 1'b0, '0);
      cycle("t4_fill");
    end
    chk("t4/push_ready_full", 32'(bus.push_ready), 32'd0);
    drive(1'b1, 32'h640, 1'b1, 32'h680, 1'b0, 1'b0, '0);  cycle("t4_overflow");
    drive(1'b1, 32'h650, 1'b1, 32'h690, 1'b1, 1'b1, 32'h640); cycle("t4_full_pushpop");
    drive(1'b1, 32'h660, 1'b1, 32'h6A0, 1'b1, 1'b1, 32'h650); cycle("t4_3_pushpop");
    chk("t4/push_ready_at3", 32'(bus.push_ready), 32'd1);
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 32'h660);        cycle("t4_drain0");
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 32'h670);        cycle("t4_drain1");
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 32'h6A0);        cycle("t4_drain2");
    chk("t4/mispredict_count", bus.mispredict_count, 32'd2);

    // Resolve with nothing queued.
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 32'h123);        cycle("t5_empty_res");
    chk("t5/res_error", 32'(bus.res_error), 32'd1);
    idle();                                                 cycle("t5_sticky");

    // Asynchronous reset landing in the flush cycle.
    drive(1'b1, 32'h700, 1'b0, 32'h0, 1'b0, 1'b0, '0);    cycle("t6_push");
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 32'h900);        cycle("t6_res");
    chk("t6/flush_before_reset", 32'(bus.flush), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6/flush", 32'(bus.flush), 32'd0);
    chk("t6/redirect_pc", bus.redirect_pc, 32'd0);
    chk("t6/branch_count", bus.branch_count, 32'd0);
    chk("t6/mispredict_count", bus.mispredict_count, 32'd0);
    chk("t6/queue_empty", 32'(bus.queue_empty), 32'd1);
    chk("t6/res_error", 32'(bus.res_error), 32'd0);
    model_reset();
    idle();
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, 32'h800, 1'b1, 32'h840, 1'b0, 1'b0, '0);  cycle("t6_resume_push");
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 32'h840);        cycle("t6_resume_res");

    // Random traffic; resolves follow the queued prediction about half the time.
    for (int n = 0; n < 400; n++) begin
      pv  = 1'($urandom_range(0, 1));
      ppc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      pt  = 1'($urandom_range(0, 1));
      ptg = 32'($urandom_range(0, 3)) * 32'h10;
      rv  = ($urandom_range(0, 2) != 0);
      if (mq.size() != 0 && $urandom_range(0, 1) == 1) begin
        rt  = mq[0].taken;
        rtg = mq[0].taken ? mq[0].tgt : 32'($urandom_range(0, 3)) * 32'h10;
      end else begin
        rt  = 1'($urandom_range(0, 1));
        rtg = 32'($urandom_range(0, 3)) * 32'h10;
      end
      drive(pv, ppc, pt, ptg, rv, rt, rtg);
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Execute-stage counterpart to the fetch-stage static predictor. It records the prediction made for every control-flow instruction fetched (branch, JAL, JALR) in a small in-order queue. When execute resolves the oldest outstanding instruction, it compares the actual outcome with the recorded prediction. On a mismatch it issues a one-cycle flush, a redirect PC for fetch, and clears all younger (wrong-path) entries. It also keeps branch and misprediction counters for performance analysis.

## Interface
- DATA_WIDTH, 32, PC/target width
- DEPTH, 4, prediction queue entries; power of two, ≥2
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- push_valid  in  1  fetch enqueues a predicted control-flow instruction
- push_pc  in  DATA_WIDTH  PC of that instruction
- push_pred_taken  in  1  predictor's direction (JALR always pushed as 0)
- push_pred_target  in  DATA_WIDTH  predictor's target (don't-care when not taken)
- push_ready  out  1  queue can accept; = !full && state==RUN
- res_valid  in  1  execute resolves the oldest queued instruction
- res_taken  in  1  actual direction
- res_target  in  DATA_WIDTH  actual target (meaningful when res_taken)
- flush  out  1  registered pulse: squash fetch/decode, redirect fetch
- redirect_pc  out  DATA_WIDTH  correct next PC, valid while flush=1
- queue_empty  out  1  no outstanding entries
- res_error  out  1  sticky: resolve arrived with empty queue
- branch_count  out  32  resolved control-flow instructions
- mispredict_count  out  32  mispredictions

## Operation
- FSM states: RUN, FLUSH. Reset → RUN.
- A push is accepted when push_valid && push_ready. The entry {pc, pred_taken, pred_target} is written at the tail.
- A resolve occurs when res_valid in RUN with the queue non-empty. It pops the head.
- mispredict = (head.pred_taken != res_taken) || (res_taken && head.pred_target != res_target).
- Correct resolve:
  - branch_count increments; no flush.
  - A simultaneous accepted push and correct resolve leaves occupancy unchanged, and both take effect.
- Mispredicting resolve:
  - branch_count and mispredict_count both increment.
  - The whole queue is cleared on that edge, including any push in the same cycle; that push is wrong-path and is dropped.
  - Next state is FLUSH.
  - redirect_pc is registered as res_target if res_taken, else head.pc + 4 (modulo 2^DATA_WIDTH).
- FLUSH lasts exactly one cycle:
  - flush=1, push_ready=0.
  - push_valid and res_valid are ignored (wrong-path).
  - Returns to RUN unconditionally.
- res_valid in RUN with an empty queue sets res_error (sticky until reset). There is no pop, no counter change and no flush.
- Counters wrap modulo 2^32.
- push_valid when full is ignored. push_ready is computed from registered state only; there is no same-cycle pass-through for a pop.

## Timing
- Reset values:
  - flush=0, redirect_pc=0, res_error=0, both counters=0.
  - Queue empty: queue_empty=1, push_ready=1.
  - state=RUN.
- Resolve at edge N: the counters update at N. flush and redirect_pc are visible in cycle N→N+1 and deasserted at N+1.
- Mispredict-to-flush latency is 1 cycle. Flush-to-first-new-push is 1 cycle; push_ready returns high in the cycle after flush.
- queue_empty and push_ready reflect occupancy after the most recent edge.
- Reset asserted mid-operation (including during FLUSH) immediately clears the queue, FSM, counters, flush and error.

## Structure
- Shared package bp_pkg:
  - bp_entry_t struct {pc, pred_target, pred_taken}, parameterised by DATA_WIDTH, or fixed at 32 with a localparam.
  - res_state_t enum {RUN, FLUSH}.
  - OPC_BRANCH=7'b1100011, OPC_JAL=7'b1101111, OPC_JALR=7'b1100111, shared with the fetch predictor.
- Sub-module pred_fifo:
  - Synchronous FIFO of bp_entry_t with push, pop, synchronous clear, full and empty.
  - Pointers are log2(DEPTH)+1 bits with wrap bit.
  - Clear has priority over push.
- branch_resolver holds the FSM, compare logic, redirect register and counters.

## Test plan
- Reset, then push pc=0x100 pred_taken=1 target=0x0F0, then resolve taken target=0x0F0 → no flush, branch_count=1, mispredict_count=0, queue_empty=1.
- Push pc=0x200 pred_taken=0, resolve taken target=0x180 → next cycle flush=1 with redirect_pc=0x180, mispredict_count=1; flush=0 the cycle after.
- Push pc=0x300 pred_taken=1 target=0x280, push two more, then resolve not-taken → redirect_pc=0x304, queue_empty=1 after edge, a same-cycle push is dropped, and push_ready=0 during flush.
- Fill 4 entries → push_ready=0, a 5th push is ignored. A simultaneous push+correct resolve from full is refused; from 3 entries it keeps occupancy at 3. Drain in FIFO order, checking PC-dependent outcomes.
- res_valid with empty queue → res_error=1 and stays 1, counters unchanged, no flush.
- Assert rst_n low during the FLUSH cycle → flush=0, redirect_pc=0, counters=0, queue_empty=1 immediately (asynchronous), and normal operation resumes after release.
